// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, addresses a combinational instruction memory,
// applies redirects/stalls, and freezes on the halt word or an out-of-range fetch.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_in,
  output logic [31:0] imem_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        halted,
  output logic        range_err,
  output logic        align_err,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state
);

  // Handshake: a word is presented every cycle; it is accepted on a rising edge
  // exactly when if_valid && !stall && !redirect. Only accepted words are counted.

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
  localparam logic [5:0]  HALT_OP    = 6'h3F;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic        range_set, align_set;
  logic        in_range, is_halt_op, count_en;
  logic [31:0] aligned_target;
  logic        unused_instr_bits;

  assign in_range          = pc[31:2] < IMEM_LIMIT;
  assign is_halt_op        = instr_in[31:26] == HALT_OP;
  assign aligned_target    = {redirect_target[31:2], 2'b00};
  assign unused_instr_bits = ^instr_in[25:0];
  assign count_en          = if_valid && !stall && !redirect && (fetch_count != 32'hFFFF_FFFF);

  // State register and architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      pc          <= RESET_PC;
      range_err   <= 1'b0;
      align_err   <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (range_set) range_err <= 1'b1;
      if (align_set) align_err <= 1'b1;
      if (count_en)  fetch_count <= fetch_count + 32'd1;
    end
  end

  // Next-state logic; priority is redirect > stall > range/halt > advance.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    range_set = 1'b0;
    align_set = 1'b0;
    case (state)
      S_INIT: begin
        if (redirect) pc_nx = redirect_target;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_nx     = aligned_target;
          align_set = redirect_target[1:0] != 2'b00;
        end else if (stall) begin
          pc_nx = pc;
        end else if (!in_range) begin
          range_set = 1'b1;
          state_nx  = S_HALT;
        end else if (is_halt_op) begin
          state_nx = S_HALT;
        end else begin
          pc_nx = pc + 32'd4;
        end
      end
      S_HALT: begin
        if (redirect) begin
          pc_nx    = aligned_target;
          state_nx = S_FETCH;
        end
      end
      default: begin
        state_nx = S_INIT;
        pc_nx    = RESET_PC;
      end
    endcase
  end

  // Outputs depend on state/pc registers only (plus instr_in for if_valid).
  always_comb begin
    imem_addr = pc;
    if_valid  = 1'b0;
    halted    = 1'b0;
    case (state)
      S_INIT:  imem_addr = 32'hFFFF_FFFC;
      S_FETCH: if_valid  = !is_halt_op && in_range;
      S_HALT:  halted    = 1'b1;
      default: imem_addr = 32'hFFFF_FFFC;
    endcase
  end

  assign if_pc     = pc;
  assign if_pc4    = pc + 32'd4;
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized and directed bench for fetch_controller: a cycle-level reference
// model predicts outputs into exp_q, and a negedge monitor pops and compares.
module tb_fetch_controller;

  localparam int          IW     = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam int          W      = 132;
  localparam int          M_INIT = 0, M_RUN = 1, M_STOP = 2;

  logic        clk, rst_n, stall, redirect;
  logic [31:0] redirect_target, instr_in;
  logic [31:0] imem_addr, if_pc, if_pc4, fetch_count;
  logic        if_valid, halted, range_err, align_err;
  logic [1:0]  dbg_state;

  logic [31:0] mem [256];
  logic [W-1:0] exp_q[$];
  int total, bad;

  // Reference model state
  int          m_mode;
  logic [31:0] m_pc, m_cnt;
  logic        m_rerr, m_aerr;

  fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(IW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .instr_in(instr_in),
    .imem_addr(imem_addr), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
    .halted(halted), .range_err(range_err), .align_err(align_err),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hFFFF_FFFC) return HALT_W;
    if (a < 32'd1024) return mem[a[9:2]];
    return 32'h0;
  endfunction

  assign instr_in = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_addr();
    return (m_mode == M_INIT) ? 32'hFFFF_FFFC : m_pc;
  endfunction

  function automatic logic m_valid();
    logic [31:0] w;
    w = mem_word(m_addr());
    return (m_mode == M_RUN) && (w[31:26] != 6'h3F) && ((m_pc >> 2) < IW);
  endfunction

  function automatic logic [W-1:0] m_outputs();
    return {m_addr(), m_pc, m_pc + 32'd4, m_cnt, m_valid(), m_mode == M_STOP, m_rerr, m_aerr};
  endfunction

  task automatic model_reset();
    m_mode = M_INIT; m_pc = 32'h0; m_cnt = 32'h0; m_rerr = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [31:0] t);
    logic [31:0] w;
    w = mem_word(m_addr());
    if (m_valid() && !s && !r && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_mode == M_INIT) begin
      if (r) m_pc = t;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (r) begin
        m_pc = t & ~32'h3;
        if (t % 4 != 0) m_aerr = 1'b1;
      end else if (s) begin
      end else if ((m_pc >> 2) >= IW) begin
        m_rerr = 1'b1;
        m_mode = M_STOP;
      end else if (w[31:26] == 6'h3F) begin
        m_mode = M_STOP;
      end else begin
        m_pc = m_pc + 4;
      end
    end else if (r) begin
      m_pc = t & ~32'h3;
      m_mode = M_RUN;
    end
  endtask

  // Driver: called at posedge+1; predicts this cycle's outputs, then steps the model.
  task automatic drive(input logic s, input logic r, input logic [31:0] t);
    stall = s; redirect = r; redirect_target = t;
    exp_q.push_back(m_outputs());
    @(negedge clk);
    @(posedge clk);
    model_step(s, r, t);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_addr",   imem_addr,        e[131:100]);
      chk("if_pc",       if_pc,            e[99:68]);
      chk("if_pc4",      if_pc4,           e[67:36]);
      chk("fetch_count", fetch_count,      e[35:4]);
      chk("if_valid",    32'(if_valid),    32'(e[3]));
      chk("halted",      32'(halted),      32'(e[2]));
      chk("range_err",   32'(range_err),   32'(e[1]));
      chk("align_err",   32'(align_err),   32'(e[0]));
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"},  imem_addr,         32'hFFFF_FFFC);
    chk({tag, "_count"}, fetch_count,       32'h0);
    chk({tag, "_rerr"},  32'(range_err),    32'h0);
    chk({tag, "_aerr"},  32'(align_err),    32'h0);
    chk({tag, "_valid"}, 32'(if_valid),     32'h0);
    chk({tag, "_halt"},  32'(halted),       32'h0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h0022_0820; mem[1] = 32'h0022_0822; mem[2] = 32'h0022_0825; mem[3] = HALT_W;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Free run into the halt word at 0xC
    repeat (7) drive(1'b0, 1'b0, 32'h0);
    chk("run_count", fetch_count, 32'd3);
    chk("run_addr", imem_addr, 32'hC);
    chk("run_halted", 32'(halted), 32'd1);
    chk("run_valid", 32'(if_valid), 32'd0);

    // Leave HALT, stall at pc=8 for three cycles, then stall+redirect together
    drive(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 20 && !(m_mode == M_RUN && m_pc == 32'h8); i++) drive(1'b0, 1'b0, 32'h0);
    chk("reach_8", imem_addr, 32'h8);
    repeat (3) drive(1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h20);
    chk("stall_redirect", imem_addr, 32'h20);

    // Run off the end of memory
    for (int i = 0; i < 60 && m_mode != M_STOP; i++) drive(1'b0, 1'b0, 32'h0);
    chk("range_err", 32'(range_err), 32'd1);
    chk("range_halt", 32'(halted), 32'd1);
    chk("range_addr", imem_addr, IW * 4);

    // Redirect out of HALT, then a misaligned redirect in FETCH
    mem[3] = 32'h0022_0820;
    drive(1'b0, 1'b1, 32'h4);
    chk("leave_halt", 32'(halted), 32'd0);
    chk("leave_addr", imem_addr, 32'h4);
    chk("leave_valid", 32'(if_valid), 32'd1);
    drive(1'b0, 1'b1, 32'h6);
    chk("align_pc", if_pc, 32'h4);
    repeat (2) drive(1'b0, 1'b0, 32'h0);
    chk("align_sticky", 32'(align_err), 32'd1);

    // Asynchronous reset in the middle of a cycle at pc=0x18
    for (int i = 0; i < 20 && m_pc != 32'h18; i++) drive(1'b0, 1'b0, 32'h0);
    chk("reach_18", imem_addr, 32'h18);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Redirect during INIT: the sentinel is not counted, first fetch is 0x40
    drive(1'b0, 1'b1, 32'h40);
    chk("init_redir_addr", imem_addr, 32'h40);
    chk("init_redir_count", fetch_count, 32'h0);
    drive(1'b0, 1'b0, 32'h0);

    // Randomized phase
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? (HALT_W | 32'($urandom_range(0, 255))) : $urandom;
    for (int i = 0; i < 500; i++) begin
      logic s, r;
      logic [31:0] t;
      s = $urandom_range(0, 3) == 0;
      r = (m_mode == M_STOP) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      t = 32'($urandom_range(0, 40)) << 2;
      if (m_mode == M_RUN && $urandom_range(0, 5) == 0) t = t | 32'($urandom_range(1, 3));
      drive(s, r, t);
    end

    @(negedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
